// File: rtl/rx_timing_pkg.sv
// Shared types and helpers for the UART receive bit-timing engine.
package rx_timing_pkg;

  localparam int CNT_W_DEF = 20;
  localparam int IDX_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HALF = 2'd1,
    BIT  = 2'd2
  } state_e;

  // Forces a zero divisor/bit-count up to 1 so a frame always has a
  // finite, non-degenerate length. Callers must keep their width <= 32.
  function automatic logic [31:0] clamp_min1(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/rx_bit_timer_tc_counter.sv
// Bit-time up-counter: counts while enabled, returns to zero on clear or
// when it reaches the compare value. tc flags the terminal count.
module tc_counter #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] cmp_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  assign tc_o = en_i && (cnt_q == cmp_i);

  // Count up; the terminal count wraps straight back to zero so the
  // counter never exceeds the compare value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              cnt_q <= '0;
    else if (clr_i || tc_o) cnt_q <= '0;
    else if (en_i)          cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/rx_bit_timer.sv
// UART receive bit-timing engine: half a bit to the start-bit centre,
// then whole bits, one strobe per cell plus a done pulse on the last.
module rx_bit_timer
  import rx_timing_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] k,
  input  logic [IDX_W-1:0] nbits,
  output logic             btu,
  output logic [IDX_W-1:0] bit_idx,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] k_lat_q, kh_lat_q;
  logic [IDX_W-1:0] n_lat_q, idx_q;
  logic             btu_q, done_q, busy_q;

  logic [CNT_W-1:0] k_c, cmp;
  logic [IDX_W-1:0] n_c, idx_nx;
  logic             cnt_clr, cnt_en, tc;

  assign k_c    = CNT_W'(clamp_min1(32'(k)));
  assign n_c    = IDX_W'(clamp_min1(32'(nbits)));
  assign idx_nx = idx_q + ONE;

  // Counter is held at zero in IDLE and on abort; one compare value per
  // timing phase.
  assign cnt_clr = abort || (state_q == IDLE);
  assign cnt_en  = (state_q == HALF) || (state_q == BIT);
  assign cmp     = (state_q == HALF) ? kh_lat_q : k_lat_q;

  tc_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cmp_i (cmp),
    .tc_o  (tc)
  );

  // Frame FSM with registered strobes; abort outranks any terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      k_lat_q  <= '0;
      kh_lat_q <= '0;
      n_lat_q  <= '0;
      idx_q    <= '0;
      btu_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      btu_q  <= 1'b0;
      done_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q  <= HALF;
              busy_q   <= 1'b1;
              k_lat_q  <= k_c;
              kh_lat_q <= k_c >> 1;
              n_lat_q  <= n_c;
              idx_q    <= '0;
            end
          end
          HALF: begin
            if (tc) begin
              btu_q <= 1'b1;
              idx_q <= '0;
              if (n_lat_q == ONE) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end else begin
                state_q <= BIT;
              end
            end
          end
          BIT: begin
            if (tc) begin
              btu_q <= 1'b1;
              idx_q <= idx_nx;
              if (idx_nx == n_lat_q - ONE) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign btu     = btu_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign bit_idx = idx_q;

endmodule
